// File: rtl/static_pkg.sv
// Shared types and helpers for the static pattern generator and its receive-side counter.
package static_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    function automatic int byte_cnt(input int ws);
        return ws / 8;
    endfunction

    function automatic int cnt_w(input int ws);
        return $clog2(ws + 1);
    endfunction

    function automatic logic [3:0] bit_count(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, b[i]};
        return c;
    endfunction

    // Rotate left: the top byte of {b,b}<<r is (b<<r)|(b>>(8-r)).
    function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] r);
        logic [15:0] t;
        t = {b, b} << r;
        return t[15:8];
    endfunction

endpackage

// File: rtl/static_gen.sv
// Emits a WORD_SIZE-bit word as a byte stream holding a programmable number of 1 bits,
// packed low-first per byte and optionally rotated by byte index.
module static_gen
    import static_pkg::*;
#(
    parameter  int WORD_SIZE = 256,
    localparam int BYTE_CNT  = byte_cnt(WORD_SIZE),
    localparam int CNT_W     = cnt_w(WORD_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] ones_target,
    input  logic             scramble,
    input  logic             cont,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_ones,
    output logic [15:0]      word_cnt
);

    localparam int               KW     = (BYTE_CNT > 1) ? $clog2(BYTE_CNT) : 1;
    localparam logic [KW-1:0]    K_LAST = KW'(BYTE_CNT - 1);
    localparam logic [CNT_W-1:0] WS_C   = CNT_W'(WORD_SIZE);
    localparam logic [CNT_W-1:0] EIGHT  = CNT_W'(8);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             scr_q, scr_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic             xfer;
    logic             load;
    logic [CNT_W-1:0] step;

    function automatic logic [7:0] pat(input logic [CNT_W-1:0] r, input logic [KW-1:0] k,
                                       input logic s);
        logic [3:0] n;
        logic [7:0] base;
        n    = (r >= EIGHT) ? 4'd8 : 4'(r);
        base = 8'hFF >> (4'd8 - n);
        return s ? rotl8(base, 3'(k)) : base;
    endfunction

    assign xfer = valid_q && out_ready;
    assign step = (rem_q >= EIGHT) ? EIGHT : rem_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        scr_d   = scr_q;
        k_d     = k_q;
        sent_d  = sent_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    load    = 1'b1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    sent_d = sent_q + CNT_W'(bit_count(data_q));
                    if (last_q) begin
                        done_d = 1'b1;
                        wcnt_d = wcnt_q + 16'd1;
                        if (cont) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        rem_d  = rem_q - step;
                        k_d    = k_q + KW'(1);
                        data_d = pat(rem_d, k_d, scr_q);
                        last_d = (k_d == K_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh word: either an accepted start or a back-to-back reload.
        if (load) begin
            rem_d   = (ones_target > WS_C) ? WS_C : ones_target;
            scr_d   = scramble;
            k_d     = '0;
            sent_d  = '0;
            valid_d = 1'b1;
            data_d  = pat(rem_d, '0, scr_d);
            last_d  = (BYTE_CNT == 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            scr_q   <= 1'b0;
            k_q     <= '0;
            sent_q  <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            scr_q   <= scr_d;
            k_q     <= k_d;
            sent_q  <= sent_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= (state_d == S_SEND);
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent_ones = sent_q;
    assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_static_gen.sv
// Bench for static_gen: table vectors, random words with stalls, back-to-back and reset cases.
module tb_static_gen;

    localparam int WS    = 256;
    localparam int NB    = WS / 8;
    localparam int CNT_W = $clog2(WS + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] ones_target;
    logic             scramble;
    logic             cont;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_ones;
    logic [15:0]      word_cnt;

    static_gen #(.WORD_SIZE(WS)) dut (
        .clk(clk), .rst(rst), .start(start), .ones_target(ones_target),
        .scramble(scramble), .cont(cont), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .sent_ones(sent_ones), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int wexp = 0;
    int exp_sum;
    logic [7:0] exp_b [NB];
    logic [7:0] got   [NB];

    typedef struct {
        int         tgt;
        bit         scr;
        logic [7:0] b0, b1, b2;
        int         sent;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: fill bytes greedily, 8 ones at a time, then rotate by index.
    task automatic model_word(input int tgt, input bit scr);
        int rem, n, b, r;
        rem = (tgt > WS) ? WS : tgt;
        exp_sum = rem;
        for (int k = 0; k < NB; k++) begin
            n = (rem < 8) ? rem : 8;
            b = (1 << n) - 1;
            r = k % 8;
            if (scr) b = ((b << r) | (b >> (8 - r))) & 255;
            exp_b[k] = 8'(b);
            rem -= n;
        end
    endtask

    task automatic run_word(input int tgt, input bit scr, input bit rnd);
        int idx, cyc;
        bit r, prev_stall;
        logic [7:0] prev_d;
        logic prev_l;
        model_word(tgt, scr);
        start = 1'b1; ones_target = CNT_W'(tgt); scramble = scr; cont = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        while (idx < NB && cyc < 2000) begin
            chk("valid_in_word", 32'(out_valid), 32'd1);
            chk("busy_in_word", 32'(busy), 32'd1);
            if (prev_stall) begin
                chk("stall_data", 32'(out_data), 32'(prev_d));
                chk("stall_last", 32'(out_last), 32'(prev_l));
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (rnd) begin
                start = 1'($urandom_range(0, 1));
                ones_target = CNT_W'($urandom_range(0, 511));
            end
            if (r) begin
                got[idx] = out_data;
                chk($sformatf("byte%0d", idx), 32'(out_data), 32'(exp_b[idx]));
                chk("last_flag", 32'(out_last), 32'(idx == NB - 1));
                idx++;
            end
            prev_stall = !r; prev_d = out_data; prev_l = out_last;
            @(posedge clk); #1;
            cyc++;
            chk("done_pulse", 32'(done), 32'(r && idx == NB));
        end
        start = 1'b0; out_ready = 1'b1;
        if (cyc >= 2000) begin
            nvec++; nmis++;
            $display("FAIL word_timeout: got %0d bytes expected %0d", idx, NB);
        end
        wexp++;
        chk("valid_after", 32'(out_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("sent_ones", 32'(sent_ones), 32'(exp_sum));
        chk("word_cnt", 32'(word_cnt), 32'(wexp));
    endtask

    vec_t vt [7];

    initial begin
        vt[0] = '{0,   1'b0, 8'h00, 8'h00, 8'h00, 0};
        vt[1] = '{256, 1'b0, 8'hFF, 8'hFF, 8'hFF, 256};
        vt[2] = '{300, 1'b0, 8'hFF, 8'hFF, 8'hFF, 256};
        vt[3] = '{13,  1'b0, 8'hFF, 8'h1F, 8'h00, 13};
        vt[4] = '{13,  1'b1, 8'hFF, 8'h3E, 8'h00, 13};
        vt[5] = '{8,   1'b0, 8'hFF, 8'h00, 8'h00, 8};
        vt[6] = '{20,  1'b1, 8'hFF, 8'hFF, 8'h3C, 20};

        rst = 1'b0; start = 1'b0; ones_target = '0; scramble = 1'b0; cont = 1'b0;
        out_ready = 1'b1;
        #3 rst = 1'b1;
        #20;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sent", 32'(sent_ones), 32'd0);
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_word(vt[i].tgt, vt[i].scr, 1'b0);
            chk("tbl_b0", 32'(got[0]), 32'(vt[i].b0));
            chk("tbl_b1", 32'(got[1]), 32'(vt[i].b1));
            chk("tbl_b2", 32'(got[2]), 32'(vt[i].b2));
            chk("tbl_sent", 32'(sent_ones), 32'(vt[i].sent));
        end

        run_word(100, 1'b0, 1'b1);
        chk("stall_sent100", 32'(sent_ones), 32'd100);
        for (int i = 0; i < 6; i++)
            run_word(int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)), 1'b1);

        // Back-to-back: two words with no gap, cont dropped inside the second.
        model_word(40, 1'b0);
        start = 1'b1; ones_target = CNT_W'(40); scramble = 1'b0; cont = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2 * NB; i++) begin
            chk("cont_valid", 32'(out_valid), 32'd1);
            chk("cont_byte", 32'(out_data), 32'(exp_b[i % NB]));
            if (i == 40) cont = 1'b0;
            @(posedge clk); #1;
            chk("cont_done", 32'(done), 32'(i == NB - 1 || i == 2 * NB - 1));
        end
        wexp += 2;
        chk("cont_idle_valid", 32'(out_valid), 32'd0);
        chk("cont_idle_busy", 32'(busy), 32'd0);
        chk("cont_wcnt", 32'(word_cnt), 32'(wexp));
        chk("cont_sent", 32'(sent_ones), 32'd40);

        // Asynchronous reset in the middle of a word.
        start = 1'b1; ones_target = CNT_W'(100); scramble = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sent", 32'(sent_ones), 32'd0);
        chk("mid_rst_wcnt", 32'(word_cnt), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        wexp = 0;
        run_word(8, 1'b0, 1'b0);
        chk("post_rst_b0", 32'(got[0]), 32'hFF);
        chk("post_rst_b1", 32'(got[1]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/static_gen.md
STATIC_GEN -- requirements
Module: static_gen

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 256: word length in bits, a multiple of 8.
REQ-002 SHALL have derived constants BYTE_CNT = WORD_SIZE/8 and CNT_W = $clog2(WORD_SIZE+1).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a word; accepted only in IDLE.
REQ-007 ones_target  input  CNT_W  number of 1 bits required in the word; sampled when start is accepted.
REQ-008 scramble  input  1  rotate pattern bytes; sampled with start.
REQ-009 cont  input  1  regenerate words back-to-back; sampled at the last byte of every word.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  sink accepts the byte; a transfer is out_valid && out_ready.
REQ-012 out_data  output  8  byte stream, byte 0 first.
REQ-013 out_last  output  1  marks byte BYTE_CNT-1.
REQ-014 busy  output  1  high in SEND.
REQ-015 done  output  1  one-cycle pulse on the transfer of the last byte.
REQ-016 sent_ones  output  CNT_W  running popcount of the bytes transferred in the current word.
REQ-017 word_cnt  output  16  completed words; wraps modulo 2^16.

Function
REQ-018 FSM SHALL have two states, IDLE and SEND; IDLE->SEND on start, SEND->IDLE on the last transfer when cont=0, SEND stays in SEND on the last transfer when cont=1.
REQ-019 Accepted start SHALL latch min(ones_target, WORD_SIZE) into the remaining-ones register rem, latch scramble, and clear the byte index k and sent_ones.
REQ-020 out_valid SHALL rise the cycle after an accepted start, presenting byte 0.
REQ-021 Unrotated byte k SHALL equal (1<<n)-1 with n = min(rem, 8); rem SHALL decrement by n on each transfer.
REQ-022 When scramble=1, byte k SHALL be rotated left by k mod 8; the popcount is unchanged.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-024 On each transfer: k increments, sent_ones adds the popcount of the transferred byte, and the next byte is presented in the following cycle with no bubble.
REQ-025 Last transfer: done=1 for one cycle and word_cnt increments; with cont=1, rem, scramble, k and sent_ones reload from the current inputs in the same cycle and out_valid stays high; otherwise out_valid=0 in the next cycle.
REQ-026 start while busy SHALL be ignored; a start coincident with the SEND->IDLE transition SHALL be ignored.
REQ-027 sent_ones SHALL hold its final value in IDLE until the next accepted start.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst SHALL force IDLE and zero out_valid, out_data, out_last, busy, done, sent_ones, word_cnt, rem and k, immediately and regardless of the clock.
REQ-030 Reset mid-word SHALL abandon the word: no done pulse, word_cnt unchanged, and the first start after release behaves as from power-up.

Structure
REQ-031 Package static_pkg SHALL hold the state enum, the BYTE_CNT/CNT_W helper functions, and a bit_count (8-bit popcount) function shared with the receive-side counter.
REQ-032 The block SHALL have no sub-module; pattern generation is combinational logic inside static_gen.

Verification (WORD_SIZE=256, out_ready=1 unless stated)
REQ-033 start, target=0 -> 32 bytes 0x00, out_last on byte 31, done one cycle, sent_ones=0, word_cnt=1.
REQ-034 target=256 -> 32 bytes 0xFF, sent_ones=256; target=300 -> identical, saturated.
REQ-035 target=13, scramble=0 -> 0xFF, 0x1F, then 30x 0x00; scramble=1 -> 0xFF, 0x3E, then 0x00.
REQ-036 target=100, out_ready toggling pseudo-randomly -> data stable while stalled, 32 ordered bytes, sent_ones=100.
REQ-037 cont=1, target=40 -> 64 contiguous valid bytes, done pulses at bytes 31 and 63, word_cnt=2; drop cont -> FSM returns to IDLE after the word in progress.
REQ-038 rst asserted at byte 10 -> all outputs 0 asynchronously; a new start of target=8 -> 0xFF, then 31x 0x00.
